// File: rtl/maj_vote_pkg.sv
// Shared types and elaboration helpers for the N-channel majority voter.
package maj_vote_pkg;

  localparam int MAX_CH  = 7;
  localparam int MAX_ERR = 15;

  typedef logic [MAX_CH-1:0]            ch_mask_t;
  typedef logic [$clog2(MAX_CH+1)-1:0]  ch_cnt_t;

  function automatic bit is_valid_cfg(input int n_ch, input int err_max);
    return (n_ch >= 3) && (n_ch <= MAX_CH) && ((n_ch % 2) == 1) &&
           (err_max >= 1) && (err_max <= MAX_ERR);
  endfunction

  function automatic ch_cnt_t popcount(input ch_mask_t v);
    ch_cnt_t c;
    c = '0;
    for (int i = 0; i < MAX_CH; i++) c += ch_cnt_t'(v[i]);
    return c;
  endfunction

  // Width of a counter that must hold every value 0..max_val.
  function automatic int cnt_width(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/maj_bit_vote.sv
// Single-bit majority across the enabled channels; flags an exact tie.
module maj_bit_vote
  import maj_vote_pkg::*;
#(
  parameter int N_CH = 3
) (
  input  logic [N_CH-1:0] bits_i,
  input  logic [N_CH-1:0] en_i,
  output logic            bit_o,
  output logic            tie_o
);

  localparam int CW = $clog2(N_CH + 1);

  logic [CW-1:0] ones;
  logic [CW-1:0] n_en;

  assign ones = CW'(popcount(ch_mask_t'(bits_i & en_i)));
  assign n_en = CW'(popcount(ch_mask_t'(en_i)));

  // 2*ones is formed by a left shift into CW+1 bits, so it never overflows.
  assign bit_o = {ones, 1'b0} >  {1'b0, n_en};
  assign tie_o = {ones, 1'b0} == {1'b0, n_en};

endmodule

// File: rtl/maj_vote_n.sv
// Registered N-channel bitwise majority voter with per-channel fault exclusion.
module maj_vote_n
  import maj_vote_pkg::*;
#(
  parameter int N_CH    = 3,
  parameter int WIDTH   = 8,
  parameter int ERR_MAX = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_i,
  input  logic [N_CH*WIDTH-1:0] data_i,
  input  logic                  clr_i,
  output logic                  valid_o,
  output logic [WIDTH-1:0]      data_o,
  output logic [N_CH-1:0]       disagree_o,
  output logic [N_CH-1:0]       fault_o,
  output logic                  no_majority_o
);

  localparam int CNT_W = cnt_width(ERR_MAX);

  if (!is_valid_cfg(N_CH, ERR_MAX)) begin : g_bad_cfg
    $error("maj_vote_n: N_CH must be odd in 3..7 and ERR_MAX in 1..15");
  end

  logic [N_CH-1:0]  en;
  logic [N_CH-1:0]  disagree_d, disagree_q;
  logic [N_CH-1:0]  fault_d, fault_q;
  logic [WIDTH-1:0] voted, tie;
  logic [WIDTH-1:0] data_q;
  logic             valid_q, no_maj_q;
  logic [CNT_W-1:0] cnt_d [N_CH];
  logic [CNT_W-1:0] cnt_q [N_CH];

  assign en = ~fault_q;

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    logic [N_CH-1:0] col;
    for (genvar k = 0; k < N_CH; k++) begin : g_col
      assign col[k] = data_i[k*WIDTH + b];
    end
    maj_bit_vote #(.N_CH(N_CH)) u_vote (
      .bits_i (col),
      .en_i   (en),
      .bit_o  (voted[b]),
      .tie_o  (tie[b])
    );
  end

  always_comb begin
    for (int k = 0; k < N_CH; k++) begin
      disagree_d[k] = en[k] && (data_i[k*WIDTH +: WIDTH] != voted);
    end
  end

  always_comb begin
    // NOTE: defaults first so every path assigns; a missing path would infer a latch.
    cnt_d   = cnt_q;
    fault_d = fault_q;
    if (clr_i) begin
      for (int k = 0; k < N_CH; k++) cnt_d[k] = '0;
      fault_d = '0;
    end else if (valid_i) begin
      for (int k = 0; k < N_CH; k++) begin
        if (!fault_q[k]) begin
          // A live counter is always below ERR_MAX, so the increment saturates by faulting.
          if (disagree_d[k]) begin
            cnt_d[k] = cnt_q[k] + 1'b1;
            if (cnt_d[k] == CNT_W'(ERR_MAX)) fault_d[k] = 1'b1;
          end else begin
            cnt_d[k] = '0;
          end
        end
      end
    end
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      data_q     <= '0;
      disagree_q <= '0;
      no_maj_q   <= 1'b0;
      fault_q    <= '0;
      // NOTE: the counters are control state, not bulk storage, so they must be reset.
      for (int k = 0; k < N_CH; k++) cnt_q[k] <= '0;
    end else begin
      valid_q <= valid_i;
      if (valid_i) begin
        data_q     <= voted;
        disagree_q <= disagree_d;
        no_maj_q   <= |tie;
      end
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  assign valid_o       = valid_q;
  assign data_o        = data_q;
  assign disagree_o    = disagree_q;
  assign fault_o       = fault_q;
  assign no_majority_o = no_maj_q;

endmodule

// File: tb/tb_maj_vote_n.sv
// Bench for maj_vote_n: directed vector table on a 3x8 voter, random traffic on 3x8 and 5x4.
module tb_maj_vote_n;

  localparam int ERR_MAX = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        a_valid_i, a_clr_i, a_valid_o, a_nm_o;
  logic [23:0] a_data_i;
  logic [7:0]  a_data_o;
  logic [2:0]  a_dis_o, a_flt_o;

  logic        b_valid_i, b_clr_i, b_valid_o, b_nm_o;
  logic [19:0] b_data_i;
  logic [3:0]  b_data_o;
  logic [4:0]  b_dis_o, b_flt_o;

  maj_vote_n #(.N_CH(3), .WIDTH(8), .ERR_MAX(ERR_MAX)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .valid_i(a_valid_i), .data_i(a_data_i), .clr_i(a_clr_i),
    .valid_o(a_valid_o), .data_o(a_data_o), .disagree_o(a_dis_o), .fault_o(a_flt_o),
    .no_majority_o(a_nm_o)
  );

  maj_vote_n #(.N_CH(5), .WIDTH(4), .ERR_MAX(ERR_MAX)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .valid_i(b_valid_i), .data_i(b_data_i), .clr_i(b_clr_i),
    .valid_o(b_valid_o), .data_o(b_data_o), .disagree_o(b_dis_o), .fault_o(b_flt_o),
    .no_majority_o(b_nm_o)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state, index 0 = DUT A, 1 = DUT B.
  int m_n[2] = '{3, 5};
  int m_w[2] = '{8, 4};
  int m_cnt[2][7];
  bit m_flt[2][7];
  bit e_valid[2];
  int e_data[2];
  int e_dis[2];
  bit e_nm[2];

  typedef struct {
    bit          v;
    bit          clr;
    logic [23:0] data;
    logic [7:0]  e_data;
    logic [2:0]  e_dis;
    logic [2:0]  e_flt;
    bit          e_nm;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int chan_word(input logic [63:0] data, input int k, input int w);
    return int'((data >> (k * w)) & ((64'd1 << w) - 64'd1));
  endfunction

  function automatic int flt_mask(input int d);
    int m;
    m = 0;
    for (int k = 0; k < 7; k++) if (m_flt[d][k]) m |= (1 << k);
    return m;
  endfunction

  // Applies one clock edge's worth of the voting rules to the model of DUT d.
  task automatic model_edge(input int d, input bit rstn, input bit v, input bit clr,
                            input logic [63:0] data);
    int n, w, n_en, ones, word, dis;
    bit nm;
    n = m_n[d];
    w = m_w[d];
    if (!rstn) begin
      e_valid[d] = 1'b0;
      e_data[d]  = 0;
      e_dis[d]   = 0;
      e_nm[d]    = 1'b0;
      for (int k = 0; k < 7; k++) begin
        m_cnt[d][k] = 0;
        m_flt[d][k] = 1'b0;
      end
      return;
    end
    e_valid[d] = v;
    if (v) begin
      n_en = 0;
      word = 0;
      dis  = 0;
      nm   = 1'b0;
      for (int k = 0; k < n; k++) if (!m_flt[d][k]) n_en++;
      for (int b = 0; b < w; b++) begin
        ones = 0;
        for (int k = 0; k < n; k++)
          if (!m_flt[d][k] && ((chan_word(data, k, w) >> b) & 1) == 1) ones++;
        if (2 * ones > n_en) word |= (1 << b);
        if (2 * ones == n_en) nm = 1'b1;
      end
      for (int k = 0; k < n; k++)
        if (!m_flt[d][k] && chan_word(data, k, w) != word) dis |= (1 << k);
      e_data[d] = word;
      e_dis[d]  = dis;
      e_nm[d]   = nm;
      if (!clr) begin
        for (int k = 0; k < n; k++) begin
          if (!m_flt[d][k]) begin
            if (((dis >> k) & 1) == 1) begin
              m_cnt[d][k]++;
              if (m_cnt[d][k] >= ERR_MAX) m_flt[d][k] = 1'b1;
            end else begin
              m_cnt[d][k] = 0;
            end
          end
        end
      end
    end
    if (clr) begin
      for (int k = 0; k < 7; k++) begin
        m_cnt[d][k] = 0;
        m_flt[d][k] = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    model_edge(0, rst_n, a_valid_i, a_clr_i, 64'(a_data_i));
    model_edge(1, rst_n, b_valid_i, b_clr_i, 64'(b_data_i));
  endtask

  task automatic cmp_a(input string tag);
    check({tag, "_a_valid"}, 64'(a_valid_o), 64'(e_valid[0]));
    check({tag, "_a_data"},  64'(a_data_o),  64'(e_data[0]));
    check({tag, "_a_dis"},   64'(a_dis_o),   64'(e_dis[0]));
    check({tag, "_a_nm"},    64'(a_nm_o),    64'(e_nm[0]));
    check({tag, "_a_flt"},   64'(a_flt_o),   64'(flt_mask(0)));
  endtask

  task automatic cmp_b(input string tag);
    check({tag, "_b_valid"}, 64'(b_valid_o), 64'(e_valid[1]));
    check({tag, "_b_data"},  64'(b_data_o),  64'(e_data[1]));
    check({tag, "_b_dis"},   64'(b_dis_o),   64'(e_dis[1]));
    check({tag, "_b_nm"},    64'(b_nm_o),    64'(e_nm[1]));
    check({tag, "_b_flt"},   64'(b_flt_o),   64'(flt_mask(1)));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_a_valid"}, 64'(a_valid_o), 64'(0));
    check({tag, "_a_data"},  64'(a_data_o),  64'(0));
    check({tag, "_a_dis"},   64'(a_dis_o),   64'(0));
    check({tag, "_a_flt"},   64'(a_flt_o),   64'(0));
    check({tag, "_a_nm"},    64'(a_nm_o),    64'(0));
    check({tag, "_b_valid"}, 64'(b_valid_o), 64'(0));
    check({tag, "_b_data"},  64'(b_data_o),  64'(0));
    check({tag, "_b_dis"},   64'(b_dis_o),   64'(0));
    check({tag, "_b_flt"},   64'(b_flt_o),   64'(0));
    check({tag, "_b_nm"},    64'(b_nm_o),    64'(0));
  endtask

  function automatic vec_t mk(input bit v, input bit clr, input logic [23:0] data,
                              input logic [7:0] ed, input logic [2:0] edis,
                              input logic [2:0] ef, input bit nm);
    vec_t r;
    r.v = v; r.clr = clr; r.data = data;
    r.e_data = ed; r.e_dis = edis; r.e_flt = ef; r.e_nm = nm;
    return r;
  endfunction

  initial begin
    logic [7:0] base;
    logic [7:0] flip;

    // Data is {ch2, ch1, ch0}; expectations are the registered outputs after the edge.
    tbl.push_back(mk(1, 0, 24'hA5A5A5, 8'hA5, 3'b000, 3'b000, 0));
    repeat (4) tbl.push_back(mk(1, 0, 24'hA4A5A5, 8'hA5, 3'b100, 3'b000, 0));
    tbl[4].e_flt = 3'b100;
    tbl.push_back(mk(1, 0, 24'h00A5A5, 8'hA5, 3'b000, 3'b100, 0));
    tbl.push_back(mk(1, 0, 24'h5AFF00, 8'h00, 3'b010, 3'b100, 1));
    tbl.push_back(mk(1, 1, 24'hFF0000, 8'h00, 3'b000, 3'b000, 0));
    tbl.push_back(mk(1, 0, 24'hFF0000, 8'h00, 3'b100, 3'b000, 0));
    tbl.push_back(mk(0, 0, 24'h123456, 8'h00, 3'b100, 3'b000, 0));
    repeat (3) tbl.push_back(mk(1, 0, 24'h111110, 8'h11, 3'b001, 3'b000, 0));
    tbl.push_back(mk(1, 0, 24'h111111, 8'h11, 3'b000, 3'b000, 0));
    repeat (3) tbl.push_back(mk(1, 0, 24'h111110, 8'h11, 3'b001, 3'b000, 0));
    tbl.push_back(mk(1, 0, 24'h111110, 8'h11, 3'b001, 3'b001, 0));
    tbl.push_back(mk(0, 1, 24'h000000, 8'h11, 3'b001, 3'b000, 0));

    rst_n     = 1'b0;
    a_valid_i = 1'b1;
    a_clr_i   = 1'b1;
    a_data_i  = 24'hFFFFFF;
    b_valid_i = 1'b1;
    b_clr_i   = 1'b0;
    b_data_i  = 20'hFFFFF;
    step();
    step();
    check_all_zero("reset");

    rst_n     = 1'b1;
    a_valid_i = 1'b0;
    a_clr_i   = 1'b0;
    b_valid_i = 1'b0;
    foreach (tbl[i]) begin
      a_valid_i = tbl[i].v;
      a_clr_i   = tbl[i].clr;
      a_data_i  = tbl[i].data;
      step();
      check($sformatf("vec%0d_valid", i), 64'(a_valid_o), 64'(tbl[i].v));
      check($sformatf("vec%0d_data", i),  64'(a_data_o),  64'(tbl[i].e_data));
      check($sformatf("vec%0d_dis", i),   64'(a_dis_o),   64'(tbl[i].e_dis));
      check($sformatf("vec%0d_flt", i),   64'(a_flt_o),   64'(tbl[i].e_flt));
      check($sformatf("vec%0d_nm", i),    64'(a_nm_o),    64'(tbl[i].e_nm));
    end

    // Mostly-agreeing channels with sporadic single-bit upsets, so faults build up.
    repeat (300) begin
      base = 8'($urandom);
      for (int k = 0; k < 3; k++) begin
        flip = ($urandom_range(0, 3) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'h00;
        a_data_i[k*8 +: 8] = base ^ flip;
      end
      a_valid_i = ($urandom_range(0, 3) != 0);
      a_clr_i   = ($urandom_range(0, 29) == 0);
      step();
      cmp_a("rnd");
    end
    a_valid_i = 1'b0;
    a_clr_i   = 1'b0;

    for (int i = 0; i < 8; i++) begin
      b_valid_i = 1'b1;
      b_data_i  = 20'($urandom);
      step();
      check($sformatf("b2b%0d_valid_high", i), 64'(b_valid_o), 64'(1));
      cmp_b($sformatf("b2b%0d", i));
    end

    rst_n    = 1'b0;
    b_data_i = 20'($urandom);
    step();
    check_all_zero("midrst");

    rst_n = 1'b1;
    repeat (6) begin
      b_data_i = 20'($urandom);
      step();
      cmp_b("post");
    end
    b_valid_i = 1'b0;
    step();
    cmp_b("idle");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
